// File: rtl/mul_pkg.sv
// Shared mode-field decoding and FSM state encoding for the iterative multiplier,
// also used by the instruction decoder and the hi/lo register file.
package mul_pkg;

    localparam int MODE_SIGNED_BIT = 0;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/mul_partial.sv
// Combinational partial-product generator: unsigned multiplicand magnitude times
// one STEP-bit slice of the multiplier magnitude.
module mul_partial #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic [WIDTH-1:0]      mcand,
    input  logic [STEP-1:0]       chunk,
    output logic [WIDTH+STEP-1:0] partial
);

    assign partial = {{STEP{1'b0}}, mcand} * {{WIDTH{1'b0}}, chunk};

endmodule

// File: rtl/mul_iter_acc.sv
// Iterative signed/unsigned multiplier with optional accumulate/subtract (MADD/MSUB),
// consuming STEP multiplier bits per cycle behind valid/ready handshakes.
module mul_iter_acc
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (WIDTH % STEP != 0) begin : g_bad_step
        $error("mul_iter_acc: WIDTH (%0d) must be a multiple of STEP (%0d)", WIDTH, STEP);
    end

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic [WIDTH-1:0]    mag_a;
    logic [WIDTH-1:0]    mag_b;
    logic                neg;
    logic [1:0]          op;
    logic [PW-1:0]       acc_q;
    logic [PW-1:0]       prod;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    in_mag_a;
    logic [WIDTH-1:0]    in_mag_b;
    logic [WIDTH+STEP-1:0] partial;
    logic [PW-1:0]       partial_ext;
    logic [PW-1:0]       signed_prod;
    logic [PW-1:0]       fix_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
        accept     = in_valid && in_ready && !flush;
        case (state)
            IDLE: if (accept) next_state = CALC;
            CALC: if (cnt == CNT_LAST) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: if (out_ready) next_state = accept ? CALC : IDLE;
            default: next_state = IDLE;
        endcase
        if (flush) next_state = IDLE;
    end

    assign busy = (state != IDLE);

    // Magnitudes are taken up front so the iterative core is purely unsigned;
    // the most negative operand maps to 2^(WIDTH-1), which still fits unsigned.
    assign in_mag_a = (mode[MODE_SIGNED_BIT] && a[WIDTH-1]) ? -a : a;
    assign in_mag_b = (mode[MODE_SIGNED_BIT] && b[WIDTH-1]) ? -b : b;

    mul_partial #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_partial (
        .mcand   (mag_a),
        .chunk   (mag_b[STEP-1:0]),
        .partial (partial)
    );

    assign partial_ext = PW'(partial);
    assign signed_prod = neg ? -prod : prod;

    always_comb begin
        fix_val = signed_prod;
        case (op)
            OP_MADD: fix_val = acc_q + signed_prod;
            OP_MSUB: fix_val = acc_q - signed_prod;
            default: fix_val = signed_prod;
        endcase
    end

    // mag_b is shifted down each CALC cycle so the low slice is always the current chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_a     <= '0;
            mag_b     <= '0;
            neg       <= 1'b0;
            op        <= OP_MUL;
            acc_q     <= '0;
            prod      <= '0;
            cnt       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                mag_a <= in_mag_a;
                mag_b <= in_mag_b;
                neg   <= mode[MODE_SIGNED_BIT] && (a[WIDTH-1] ^ b[WIDTH-1]);
                op    <= mode[2:1];
                acc_q <= acc;
                prod  <= '0;
                cnt   <= '0;
            end
            case (state)
                CALC: begin
                    prod  <= prod + (partial_ext << (int'(cnt) * STEP));
                    mag_b <= mag_b >> STEP;
                    cnt   <= cnt + 1'b1;
                end
                FIX: begin
                    result    <= fix_val;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_iter_acc.sv
// Scoreboard bench for mul_iter_acc: directed corner cases, flush, stall and reset
// behaviour, randomized traffic against a plain-arithmetic model, and alternate STEP builds.
module tb_mul_iter_acc;

    typedef struct {
        logic [63:0] exp;
        int          acc_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  mode = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [63:0] acc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    logic        alt_valid = 1'b0;
    logic [2:0]  alt_mode = '0;
    logic [31:0] alt_a = '0;
    logic [31:0] alt_b = '0;
    logic        in_ready_s1, out_valid_s1, busy_s1;
    logic        in_ready_s32, out_valid_s32, busy_s32;
    logic [63:0] result_s1, result_s32;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ready_mode = 0;
    bit   prev_valid = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mul_iter_acc #(.WIDTH(32), .STEP(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .acc(acc), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    mul_iter_acc #(.WIDTH(32), .STEP(1)) dut_s1 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(alt_valid), .in_ready(in_ready_s1),
        .mode(alt_mode), .a(alt_a), .b(alt_b), .acc(64'd0), .out_valid(out_valid_s1),
        .out_ready(1'b1), .result(result_s1), .busy(busy_s1)
    );

    mul_iter_acc #(.WIDTH(32), .STEP(32)) dut_s32 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(alt_valid), .in_ready(in_ready_s32),
        .mode(alt_mode), .a(alt_a), .b(alt_b), .acc(64'd0), .out_valid(out_valid_s32),
        .out_ready(1'b1), .result(result_s32), .busy(busy_s32)
    );

    always @(posedge clk) cyc = cyc + 1;

    // Consumer backpressure: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Reference: sign/zero extend to 64 bits, multiply, then accumulate modulo 2^64.
    function automatic logic [63:0] model(input logic [2:0] m, input logic [31:0] av,
                                          input logic [31:0] bv, input logic [63:0] accv);
        logic [63:0] ea, eb, p;
        ea = m[0] ? {{32{av[31]}}, av} : {32'd0, av};
        eb = m[0] ? {{32{bv[31]}}, bv} : {32'd0, bv};
        p  = ea * eb;
        case (m[2:1])
            2'b01:   return accv + p;
            2'b10:   return accv - p;
            default: return p;
        endcase
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: condition not reached within bound (cycle %0d)", name, cyc);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [63:0] accv, input bit use_exp,
                                 input logic [63:0] expv, output int waited);
        exp_t e;
        bit   done;
        done     = 1'b0;
        waited   = 0;
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        b        = bv;
        acc      = accv;
        e.exp    = use_exp ? expv : model(m, av, bv, accv);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                e.acc_cyc = cyc + 1;
                sb.push_back(e);
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        acc      = {$urandom, $urandom};
        if (!done) failNow("accept_timeout");
    endtask

    task automatic waitDrain();
        bit drained;
        drained = 1'b0;
        for (int i = 0; i < 300 && !drained; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !out_valid) drained = 1'b1;
        end
        if (!drained) begin
            failNow("drain_timeout");
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runAlt(input logic [2:0] m, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] expv);
        int acc_cyc;
        bit seen1, seen32;
        seen1     = 1'b0;
        seen32    = 1'b0;
        alt_valid = 1'b1;
        alt_mode  = m;
        alt_a     = av;
        alt_b     = bv;
        checkOutput("alt_in_ready", {62'd0, in_ready_s1, in_ready_s32}, 64'd3);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        alt_valid = 1'b0;
        checkOutput("alt_busy", {62'd0, busy_s1, busy_s32}, 64'd3);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid_s1 && !seen1) begin
                seen1 = 1'b1;
                checkOutput("s1_latency", 64'(cyc - acc_cyc), 64'd33);
                checkOutput("s1_result", result_s1, expv);
            end
            if (out_valid_s32 && !seen32) begin
                seen32 = 1'b1;
                checkOutput("s32_latency", 64'(cyc - acc_cyc), 64'd2);
                checkOutput("s32_result", result_s32, expv);
            end
        end
        if (!seen1) failNow("s1_out_valid");
        if (!seen32) failNow("s32_out_valid");
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks latency and value when a result appears, pops on handshake.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    if (!prev_valid) failNow("spurious_out_valid");
                end else begin
                    if (!prev_valid) begin
                        checkOutput("latency", 64'(cyc - sb[0].acc_cyc), 64'd5);
                        checkOutput("result_rise", result, sb[0].exp);
                    end
                    if (!out_ready) checkOutput("in_ready_stalled", {63'd0, in_ready}, 64'd0);
                    else begin
                        checkOutput("result_handshake", result, sb[0].exp);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int  w;
        bit  rose;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed products and accumulates");
        applyStimulus(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFE, w);
        applyStimulus(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1, 64'hFFFF_FFFE_0000_0001, w);
        applyStimulus(3'b001, 32'h8000_0000, 32'h8000_0000, 64'd0, 1, 64'h4000_0000_0000_0000, w);
        applyStimulus(3'b011, 32'h0000_0003, 32'hFFFF_FFFC, 64'h10, 1, 64'h0000_0000_0000_0004, w);
        applyStimulus(3'b100, 32'h0000_0001, 32'h0000_0001, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, w);
        applyStimulus(3'b111, 32'h0000_0005, 32'hFFFF_FFFF, 64'h1234, 1, 64'hFFFF_FFFF_FFFF_FFFB, w);
        waitDrain();

        $display("[TB] flush during CALC");
        applyStimulus(3'b000, 32'h0001_0000, 32'h0000_0003, 64'd0, 1, 64'h0000_0000_0003_0000, w);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        checkOutput("flush_busy", {63'd0, busy}, 64'd0);
        rose = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        checkOutput("flush_no_out_valid", {63'd0, rose}, 64'd0);
        @(posedge clk);
        #1;
        applyStimulus(3'b001, 32'd7, 32'd6, 64'd0, 1, 64'h0000_0000_0000_002A, w);
        waitDrain();

        $display("[TB] stall in DONE then back-to-back accept");
        ready_mode = 2;
        applyStimulus(3'b000, 32'h0001_0000, 32'h0001_0000, 64'd0, 1, 64'h0000_0001_0000_0000, w);
        rose = 1'b0;
        for (int i = 0; i < 20 && !rose; i++) begin
            @(negedge clk);
            if (out_valid) rose = 1'b1;
        end
        if (!rose) failNow("stall_out_valid");
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_result", result, 64'h0000_0001_0000_0000);
            checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        applyStimulus(3'b101, 32'hFFFF_FFFE, 32'd3, 64'd100, 1, 64'h0000_0000_0000_006A, w);
        checkOutput("b2b_same_edge", 64'(w), 64'd0);
        waitDrain();

        $display("[TB] randomized traffic");
        ready_mode = 1;
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  rm;
            logic [31:0] ra, rb;
            logic [63:0] racc;
            rm   = 3'($urandom_range(0, 7));
            ra   = pickOperand();
            rb   = pickOperand();
            racc = {$urandom, $urandom};
            applyStimulus(rm, ra, rb, racc, 0, 64'd0, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        waitDrain();

        $display("[TB] STEP=1 and STEP=32 builds");
        runAlt(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFE);
        runAlt(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        runAlt(3'b001, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

        $display("[TB] async reset mid-CALC");
        applyStimulus(3'b000, 32'd5, 32'd9, 64'd0, 0, 64'd0, w);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("arst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("arst_busy", {63'd0, busy}, 64'd0);
        checkOutput("arst_result", result, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(3'b001, 32'hFFFF_FFFD, 32'd3, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFF7, w);
        waitDrain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
